// File: rtl/moore_seq_gen_pkg.sv
// Shared types and defaults for the 11001 serial pattern source.
// Imported by the interface and the transmitter core.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int         DEF_PAT_W   = 5;
    localparam logic [4:0] DEF_PATTERN = 5'b11001;

endpackage

// File: rtl/moore_seq_gen_if.sv
// Control/stream bundle between a burst requester and the pattern transmitter.
// master drives the request fields, slave (the transmitter) drives the serial stream.
interface moore_seq_gen_if #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) ();

    logic             start;
    logic [CNT_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap_cyc;
    logic             out;
    logic             out_vld;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output rep_cnt,
        output gap_cyc,
        input  out,
        input  out_vld,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  rep_cnt,
        input  gap_cyc,
        output out,
        output out_vld,
        output busy,
        output done
    );

endinterface

// File: rtl/moore_seq_gen.sv
// Serial Moore transmitter: emits PATTERN MSB first rep_cnt times with gap_cyc idle cycles between frames.
// Latency: start sampled at edge k gives the first frame bit during cycle k+1; done pulses one cycle after the last bit.
// Backpressure: none; start is only honoured in IDLE, requests while busy or in DONE are dropped, not queued.
module moore_seq_gen
    import seq_gen_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter int               CNT_W   = 8,
    parameter int               GAP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    moore_seq_gen_if.slave    bus
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0] ONE_REP  = CNT_W'(1);
    localparam logic [GAP_W-1:0] ONE_GAP  = GAP_W'(1);

    state_t           state;
    logic [IDX_W-1:0] bit_idx;
    logic [IDX_W-1:0] idx_dec;
    logic [CNT_W-1:0] reps_left;
    logic [GAP_W-1:0] gap_left;
    logic [GAP_W-1:0] gap_reg;

    logic out_q;
    logic out_vld_q;
    logic busy_q;
    logic done_q;

    always_comb begin
        idx_dec = bit_idx - 1'b1;
    end

    // Outputs are registered alongside the state they belong to, so each
    // branch loads the output values of the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_idx   <= '0;
            reps_left <= '0;
            gap_left  <= '0;
            gap_reg   <= '0;
            out_q     <= 1'b0;
            out_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_q     <= 1'b0;
                    out_vld_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    if (bus.start && (bus.rep_cnt != '0)) begin
                        reps_left <= bus.rep_cnt;
                        gap_reg   <= bus.gap_cyc;
                        bit_idx   <= LAST_IDX;
                        state     <= SEND;
                        out_q     <= PATTERN[LAST_IDX];
                        out_vld_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end

                SEND: begin
                    busy_q <= 1'b1;
                    done_q <= 1'b0;
                    if (bit_idx != '0) begin
                        bit_idx   <= idx_dec;
                        out_q     <= PATTERN[idx_dec];
                        out_vld_q <= 1'b1;
                    end else if (reps_left == ONE_REP) begin
                        reps_left <= '0;
                        state     <= DONE;
                        out_q     <= 1'b0;
                        out_vld_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (gap_reg == '0) begin
                        reps_left <= reps_left - ONE_REP;
                        bit_idx   <= LAST_IDX;
                        out_q     <= PATTERN[LAST_IDX];
                        out_vld_q <= 1'b1;
                    end else begin
                        reps_left <= reps_left - ONE_REP;
                        gap_left  <= gap_reg;
                        state     <= GAP;
                        out_q     <= 1'b0;
                        out_vld_q <= 1'b0;
                    end
                end

                GAP: begin
                    busy_q   <= 1'b1;
                    done_q   <= 1'b0;
                    gap_left <= gap_left - ONE_GAP;
                    if (gap_left == ONE_GAP) begin
                        bit_idx   <= LAST_IDX;
                        state     <= SEND;
                        out_q     <= PATTERN[LAST_IDX];
                        out_vld_q <= 1'b1;
                    end else begin
                        out_q     <= 1'b0;
                        out_vld_q <= 1'b0;
                    end
                end

                DONE: begin
                    state     <= IDLE;
                    out_q     <= 1'b0;
                    out_vld_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    out_q     <= 1'b0;
                    out_vld_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out     = out_q;
    assign bus.out_vld = out_vld_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_moore_seq_gen.sv
// Directed bench for moore_seq_gen: hand-computed per-cycle streams, reset abort,
// ignored requests, counter limit and loopback into a non-overlapping 11001 detector.
module tb_moore_seq_gen;

    logic clk;
    logic reset;

    int n_assert = 0;
    int n_fail   = 0;

    moore_seq_gen_if bus ();

    moore_seq_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference non-overlapping 11001 detector (Moore, flags one cycle after the final bit).
    logic [2:0] dst;
    logic       last_end;
    logic       det_clr;
    int         det_cnt;
    int         det_aligned;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dst      <= 3'd0;
            last_end <= 1'b0;
        end else begin
            last_end <= bus.out_vld && bus.out;
            case (dst)
                3'd0:    dst <= bus.out ? 3'd1 : 3'd0;
                3'd1:    dst <= bus.out ? 3'd2 : 3'd0;
                3'd2:    dst <= bus.out ? 3'd2 : 3'd3;
                3'd3:    dst <= bus.out ? 3'd1 : 3'd4;
                3'd4:    dst <= bus.out ? 3'd5 : 3'd0;
                default: dst <= bus.out ? 3'd1 : 3'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (det_clr) begin
            det_cnt     <= 0;
            det_aligned <= 0;
        end else if (dst == 3'd5) begin
            det_cnt <= det_cnt + 1;
            if (last_end) det_aligned <= det_aligned + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".out"},     32'(bus.out),     32'd0);
        chk({tag, ".out_vld"}, 32'(bus.out_vld), 32'd0);
        chk({tag, ".busy"},    32'(bus.busy),    32'd0);
        chk({tag, ".done"},    32'(bus.done),    32'd0);
    endtask

    // Starts a burst, then compares n cycles against hand-written vectors (first cycle = MSB).
    // With hold set, start stays high through the whole burst and the DONE cycle.
    task automatic run_burst(input string tag, input logic [7:0] rep, input logic [3:0] gap,
                             input int n, input logic [31:0] vld_v, input logic [31:0] out_v,
                             input logic [31:0] done_v, input bit hold);
        logic [31:0] vv;
        logic [31:0] ov;
        logic [31:0] dv;
        vv = vld_v;
        ov = out_v;
        dv = done_v;
        bus.start   = 1'b1;
        bus.rep_cnt = rep;
        bus.gap_cyc = gap;
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        bus.rep_cnt = 8'd7;
        bus.gap_cyc = 4'd9;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.c%0d.out_vld", tag, i), 32'(bus.out_vld), 32'(vv[n-1-i]));
            chk($sformatf("%s.c%0d.out", tag, i),     32'(bus.out),     32'(ov[n-1-i]));
            chk($sformatf("%s.c%0d.done", tag, i),    32'(bus.done),    32'(dv[n-1-i]));
            chk($sformatf("%s.c%0d.busy", tag, i),    32'(bus.busy),    32'd1);
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk_idle({tag, ".after"});
        @(negedge clk);
        chk_idle({tag, ".after2"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vld_cnt;
        int busy_cnt;
        int done_cnt;
        int cyc;

        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.rep_cnt = '0;
        bus.gap_cyc = '0;
        det_clr     = 1'b1;

        // Reset held while idle
        repeat (2) @(negedge clk);
        chk_idle("reset");
        reset = 1'b1;
        @(negedge clk);
        chk_idle("post_reset");

        // Single frame, no gap: 11001 then done
        run_burst("r1g0", 8'd1, 4'd0, 6, 32'b111110, 32'b110010, 32'b000001, 1'b0);

        // Three frames with a two-cycle gap: 20 busy cycles
        run_burst("r3g2", 8'd3, 4'd2, 20,
                  32'b11111001111100111110,
                  32'b11001001100100110010,
                  32'b00000000000000000001, 1'b0);

        // Two frames back to back: 1100111001
        run_burst("r2g0", 8'd2, 4'd0, 11, 32'b11111111110, 32'b11001110010, 32'b00000000001, 1'b0);

        // Zero repetitions is ignored
        bus.start   = 1'b1;
        bus.rep_cnt = 8'd0;
        bus.gap_cyc = 4'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_idle($sformatf("rep0.c%0d", i));
        end
        bus.start = 1'b0;

        // Reset mid-frame after two bits of a four-frame burst
        bus.start   = 1'b1;
        bus.rep_cnt = 8'd4;
        bus.gap_cyc = 4'd0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("abort.b0.out", 32'(bus.out), 32'd1);
        @(negedge clk);
        chk("abort.b1.out", 32'(bus.out), 32'd1);
        chk("abort.b1.busy", 32'(bus.busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_idle("abort.async");
        @(negedge clk);
        chk_idle("abort.held");
        reset = 1'b1;
        @(negedge clk);
        chk_idle("abort.release");
        run_burst("clean", 8'd1, 4'd0, 6, 32'b111110, 32'b110010, 32'b000001, 1'b0);

        // Loopback into detector, start held high throughout the burst
        det_clr = 1'b1;
        @(negedge clk);
        det_clr = 1'b0;
        run_burst("loop", 8'd5, 4'd1, 30,
                  32'b111110111110111110111110111110,
                  32'b110010110010110010110010110010,
                  32'b000000000000000000000000000001, 1'b1);
        @(negedge clk);
        chk("loop.det_cnt", 32'(det_cnt), 32'd5);
        chk("loop.det_aligned", 32'(det_aligned), 32'd5);

        // Maximum repetition count must not wrap: 255 frames, no gap
        bus.start   = 1'b1;
        bus.rep_cnt = 8'd255;
        bus.gap_cyc = 4'd0;
        @(negedge clk);
        bus.start = 1'b0;
        vld_cnt  = 0;
        busy_cnt = 0;
        done_cnt = 0;
        cyc      = 0;
        while (bus.busy && cyc < 3000) begin
            vld_cnt  += int'(bus.out_vld);
            busy_cnt += 1;
            done_cnt += int'(bus.done);
            cyc++;
            @(negedge clk);
        end
        chk("max.vld_cycles", 32'(vld_cnt), 32'd1275);
        chk("max.busy_cycles", 32'(busy_cnt), 32'd1276);
        chk("max.done_pulses", 32'(done_cnt), 32'd1);
        chk_idle("max.after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/moore_seq_gen.md
Name: moore_seq_gen

Overview:
- Serial Moore-style pattern transmitter that emits the 5-bit frame 11001, MSB first, a programmable number of times.
- Consecutive frames are separated by a programmable idle gap.
- It is the source end of the 11001 detector path: it drives stimulus and link traffic into the non-overlapping 11001 sequence detector.
- All outputs are decoded from registered state only (Moore); there is no combinational path from any input to any output.

Parameters:
- PAT_W, 5, frame length in bits.
- PATTERN, 5'b11001, frame bits, transmitted MSB first.
- CNT_W, 8, width of the repetition count.
- GAP_W, 4, width of the inter-frame gap count.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- start  input  1  request to begin a burst; sampled only in IDLE.
- rep_cnt  input  CNT_W  number of frames in the burst; captured on an accepted start.
- gap_cyc  input  GAP_W  idle cycles between frames; captured on an accepted start.
- out  output  1  serial data bit.
- out_vld  output  1  high while out carries a frame bit.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle pulse after the last bit of the burst.

Behaviour:
- Reset:
  - reset=0 forces state IDLE asynchronously, including mid-burst.
  - While in reset: out=0, out_vld=0, busy=0, done=0, all counters 0.
  - A partial frame is abandoned, not completed.
- States: IDLE, SEND, GAP, DONE. Registers: bit_idx (log2 PAT_W bits), reps_left (CNT_W), gap_left (GAP_W), gap_reg (GAP_W).
- IDLE:
  - Outputs all 0.
  - If start=1 and rep_cnt!=0: capture reps_left=rep_cnt and gap_reg=gap_cyc, set bit_idx=PAT_W-1, go to SEND.
  - If start=1 and rep_cnt==0: ignored; stay in IDLE, no done pulse.
- SEND:
  - out=PATTERN[bit_idx], out_vld=1, busy=1.
  - If bit_idx!=0: bit_idx decrements each cycle.
  - If bit_idx==0 and reps_left==1: go to DONE.
  - If bit_idx==0, reps_left>1 and gap_reg==0: reps_left decrements, bit_idx reloads to PAT_W-1, stay in SEND (back-to-back frames).
  - If bit_idx==0, reps_left>1 and gap_reg!=0: reps_left decrements, gap_left=gap_reg, go to GAP.
- GAP:
  - out=0, out_vld=0, busy=1.
  - gap_left decrements each cycle.
  - When gap_left==1: bit_idx=PAT_W-1, go to SEND.
  - Exactly gap_reg idle cycles occur.
- DONE: done=1, busy=1, out=0, out_vld=0 for exactly one cycle, then IDLE.
- Latency:
  - start sampled high at edge k → first bit (1) on out during cycle k+1.
  - A burst of R frames with gap G occupies R*PAT_W + (R-1)*G cycles of SEND/GAP, followed by one DONE cycle.
- start while busy or in DONE is ignored; there is no queueing.
- rep_cnt and gap_cyc changes after capture have no effect on the burst in progress.
- rep_cnt=2^CNT_W-1 is legal; the counters must not wrap.
- Next-state logic has default → IDLE for unreachable encodings.

Decomposition:
- Package seq_gen_pkg holds:
  - state enum typedef (logic [1:0]: IDLE, SEND, GAP, DONE);
  - constant DEF_PATTERN=5'b11001;
  - constant DEF_PAT_W=5.
- Single module; no sub-module is warranted.

Test Plan:
- Reset during IDLE, then start=1, rep_cnt=1, gap_cyc=0 → out=1,1,0,0,1 with out_vld=1 on cycles k+1..k+5; done=1 on k+6; busy low on k+7.
- rep_cnt=3, gap_cyc=2 → three 11001 frames, each separated by exactly 2 cycles of out_vld=0; a single done after the 3rd frame; 20 busy cycles total (15 SEND + 4 GAP + 1 DONE).
- rep_cnt=2, gap_cyc=0 → 10 consecutive out_vld cycles with bit stream 1100111001, then done.
- start=1 with rep_cnt=0 → state stays IDLE; busy, out_vld and done stay 0 for 10 cycles.
- reset pulled low mid-frame after 2 bits of a rep_cnt=4 burst → outputs go to 0 immediately without waiting for clk; after release, a new start (rep_cnt=1) yields a clean 11001.
- Loopback into the 11001 detector with rep_cnt=5, gap_cyc=1 → detector out pulses exactly 5 times, one cycle after each frame's last bit; start pulses while busy=1 produce no extra frames.
